// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the decode-stage register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } regfile_state_e;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefNumRd   = 2;
  localparam bit          DefZeroReg = 1'b1;

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset sweep sequencer: walks every entry once, then raises ready.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              ready_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  regfile_state_e    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_o  = 1'b0;
    clr_en_o = 1'b0;
    unique case (state_q)
      StInit: begin
        // Gate on reset so a held reset never touches storage.
        clr_en_o = !rst_i;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        ready_o = 1'b1;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign clr_addr_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and post-reset sweep clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter bit          ZERO_REG = DefZeroReg
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              run_en;
  logic              wr_ok;
  logic              rsv_ok;

  regfile_init_fsm #(
    .ADDR_W (ADDR_W)
  ) u_init_fsm (
    .clk_i      (clk),
    .rst_i      (rst),
    .ready_o    (ready),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  assign run_en = ready && !rst;
  assign wr_ok  = run_en && wr_en  && !(ZERO_REG && (wr_addr == '0));
  assign rsv_ok = run_en && rsv_en && !(ZERO_REG && (rsv_addr == '0));

  // No reset on storage: the sweep clears it so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr]  <= '0;
      busy_q[clr_addr] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr]  <= wr_data;
        busy_q[wr_addr] <= 1'b0;
      end
      // Later assignment wins: a new reservation overrides the write's clear.
      if (rsv_ok) begin
        busy_q[rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              byp;

    assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && (ra == '0);
`ifdef REGFILE_BYPASS_EN
    assign byp = run_en && wr_en && (wr_addr == ra) && !is_zero;
`else
    assign byp = 1'b0;
`endif

    assign rd_data[k*DATA_W +: DATA_W] = (!ready || is_zero) ? '0      :
                                         byp                 ? wr_data :
                                                               mem_q[ra];
    assign rd_busy[k] = (!ready || is_zero || byp) ? 1'b0 : busy_q[ra];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        ready;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  int n_checks;
  int n_errors;
  int edges;

  regfile_sb u_dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Counts edges until ready, bounded so a stuck sweep still reaches the summary.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
      if (n == 5) begin
        check("init_rd_data", 32'(rd_data), 32'h0);
        check("init_rd_busy", 32'(rd_busy), 32'h0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    set_rd(5'd0, 5'd0);

    // Reset sweep, with writes and reservations attempted during INIT.
    repeat (3) step();
    check("reset_ready", 32'(ready), 32'h0);
    rst      = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 8'hFF;
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    set_rd(5'd3, 5'd5);
    wait_ready(edges);
    check("sweep_edges", 32'(edges), 32'd32);
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    #1;
    check("init_wr_dropped", 32'(rd_data[7:0]), 32'h00);
    check("init_rsv_dropped", 32'(rd_busy[0]), 32'h0);

    // Basic write/read.
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 8'hA5;
    set_rd(5'd5, 5'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same_cycle", 32'(rd_data[7:0]), 32'hA5);
`else
    check("wr_same_cycle", 32'(rd_data[7:0]), 32'h00);
`endif
    step();
    wr_en = 1'b0;
    #1;
    check("wr_next_p0", 32'(rd_data[7:0]), 32'hA5);
    check("wr_next_p1", 32'(rd_data[15:8]), 32'hA5);

    // Zero register.
    wr_en    = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 8'h3C;
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    step();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    #1;
    check("zero_data", 32'(rd_data), 32'h0);
    check("zero_busy", 32'(rd_busy), 32'h0);
    repeat (3) step();
    check("zero_data_later", 32'(rd_data), 32'h0);

    // Scoreboard: reserve, then write and reserve on the same edge.
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    set_rd(5'd7, 5'd5);
    #1;
    check("sb_before", 32'(rd_busy[0]), 32'h0);
    step();
    rsv_en = 1'b0;
    #1;
    check("sb_set", 32'(rd_busy[0]), 32'h1);
    check("sb_other", 32'(rd_busy[1]), 32'h0);
    step();
    check("sb_hold", 32'(rd_busy[0]), 32'h1);
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 8'h11;
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    step();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    #1;
    check("sb_combo_busy", 32'(rd_busy[0]), 32'h1);
    check("sb_combo_data", 32'(rd_data[7:0]), 32'h11);

    // Write to a busy register while port 1 reads it.
    rsv_en   = 1'b1;
    rsv_addr = 5'd6;
    step();
    rsv_en  = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd6;
    wr_data = 8'h5A;
    set_rd(5'd5, 5'd6);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", 32'(rd_data[15:8]), 32'h5A);
    check("byp_busy", 32'(rd_busy[1]), 32'h0);
`else
    check("nobyp_data", 32'(rd_data[15:8]), 32'h00);
    check("nobyp_busy", 32'(rd_busy[1]), 32'h1);
`endif
    check("byp_p0_data", 32'(rd_data[7:0]), 32'hA5);
    check("byp_p0_busy", 32'(rd_busy[0]), 32'h0);
    step();
    wr_en = 1'b0;
    #1;
    check("byp_after_data", 32'(rd_data[15:8]), 32'h5A);
    check("byp_after_busy", 32'(rd_busy[1]), 32'h0);

    // Reset mid-run: sweep restarts and clears everything.
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    step();
    rsv_en = 1'b0;
    rst    = 1'b1;
    step();
    check("midrst_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    wait_ready(edges);
    check("midrst_edges", 32'(edges), 32'd32);
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      check($sformatf("clr_data_%0d", a), 32'(rd_data), 32'h0);
      check($sformatf("clr_busy_%0d", a), 32'(rd_busy), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
